// File: rtl/dest_tag_pipeline_if.sv
// Operand-forwarding producer interface: ID-stage tag/source inputs, branch/memory
// control, and the EX/MEM and MEM/WB destination tags plus hazard/perf outputs.
interface dest_tag_pipeline_if #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] rd_id;
  logic                  reg_write_id;
  logic                  mem_read_id;
  logic [REG_ADDR_W-1:0] rn_id;
  logic [REG_ADDR_W-1:0] rm_id;
  logic                  use_rn_id;
  logic                  use_rm_id;
  logic                  flush_ex;
  logic                  mem_hold;
  logic                  stall_id;
  logic [REG_ADDR_W-1:0] rd_exmem;
  logic                  reg_write_en_exmem;
  logic [REG_ADDR_W-1:0] rd_memwb;
  logic                  reg_write_en_memwb;
  logic                  wb_retire;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      retire_count;

  modport master (
    output id_valid, rd_id, reg_write_id, mem_read_id, rn_id, rm_id,
           use_rn_id, use_rm_id, flush_ex, mem_hold,
    input  stall_id, rd_exmem, reg_write_en_exmem, rd_memwb,
           reg_write_en_memwb, wb_retire, stall_count, retire_count
  );

  modport slave (
    input  id_valid, rd_id, reg_write_id, mem_read_id, rn_id, rm_id,
           use_rn_id, use_rm_id, flush_ex, mem_hold,
    output stall_id, rd_exmem, reg_write_en_exmem, rd_memwb,
           reg_write_en_memwb, wb_retire, stall_count, retire_count
  );
endinterface

// File: rtl/dest_tag_pipeline.sv
// Carries destination tags through ID/EX, EX/MEM, MEM/WB; detects load-use hazards
// and sequences hold/flush for tags, with stall and retire counters.
module dest_tag_pipeline #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input logic                clk,
  input logic                rst_n,
  dest_tag_pipeline_if.slave bus
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } tag_t;

  tag_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_tag_s;
  logic load_use_s, stall_s;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, retire_cnt_q, retire_cnt_d;

  // Hazard detection: a load in EX whose result the ID instruction needs now.
  always_comb begin
    id_tag_s   = {bus.id_valid, bus.rd_id, bus.reg_write_id, bus.mem_read_id};
    load_use_s = 1'b0;
    if (bus.id_valid && ex_q.valid && ex_q.mem_read && ex_q.reg_write &&
        (ex_q.rd != {REG_ADDR_W{1'b0}})) begin
      load_use_s = (bus.use_rn_id && (bus.rn_id == ex_q.rd)) ||
                   (bus.use_rm_id && (bus.rm_id == ex_q.rd));
    end else begin
      load_use_s = 1'b0;
    end
    stall_s = load_use_s | bus.mem_hold;
  end

  // Stage advance: hold beats flush beats load-use bubble beats normal flow.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (bus.mem_hold) begin
      // WB drains to a bubble so its instruction retires only once.
      wb_d       = mem_q;
      wb_d.valid = 1'b0;
    end else if (bus.flush_ex || load_use_s) begin
      ex_d       = id_tag_s;
      ex_d.valid = 1'b0;
      mem_d      = ex_q;
      wb_d       = mem_q;
    end else begin
      ex_d  = id_tag_s;
      mem_d = ex_q;
      wb_d  = mem_q;
    end
  end

  // Performance counters: stall saturates, retire wraps.
  always_comb begin
    if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (wb_q.valid) begin
      retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retire_cnt_d = retire_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      stall_cnt_q  <= {CNT_W{1'b0}};
      retire_cnt_q <= {CNT_W{1'b0}};
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      stall_cnt_q  <= stall_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign bus.stall_id           = stall_s;
  assign bus.rd_exmem           = mem_q.rd;
  assign bus.reg_write_en_exmem = mem_q.valid & mem_q.reg_write;
  assign bus.rd_memwb           = wb_q.rd;
  assign bus.reg_write_en_memwb = wb_q.valid & wb_q.reg_write;
  assign bus.wb_retire          = wb_q.valid;
  assign bus.stall_count        = stall_cnt_q;
  assign bus.retire_count       = retire_cnt_q;

endmodule

// File: tb/tb_dest_tag_pipeline.sv
// Bench for dest_tag_pipeline: directed literal cases plus randomized traffic
// compared every cycle against an array-based pipeline model.
module tb_dest_tag_pipeline;
  localparam int RW   = 4;
  localparam int CW   = 4;
  localparam int SAT  = (1 << CW) - 1;
  localparam int WRAP = (1 << CW);

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  dest_tag_pipeline_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

  dest_tag_pipeline #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: index 0 = EX, 1 = MEM, 2 = WB.
  int m_v[3], m_rd[3], m_rw[3], m_mr[3];
  int m_sc, m_rc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_v[i] = 0; m_rd[i] = 0; m_rw[i] = 0; m_mr[i] = 0;
    end
    m_sc = 0;
    m_rc = 0;
  endtask

  function automatic bit model_lu();
    bit src_hit;
    src_hit = (bus.use_rn_id && (int'(bus.rn_id) == m_rd[0])) ||
              (bus.use_rm_id && (int'(bus.rm_id) == m_rd[0]));
    return bus.id_valid && (m_v[0] != 0) && (m_mr[0] != 0) && (m_rw[0] != 0) &&
           (m_rd[0] != 0) && src_hit;
  endfunction

  task automatic model_step();
    bit lu;
    lu = model_lu();
    if (lu || bus.mem_hold) m_sc = (m_sc == SAT) ? SAT : m_sc + 1;
    if (m_v[2] != 0) m_rc = (m_rc + 1) % WRAP;
    if (bus.mem_hold) begin
      m_v[2] = 0;
    end else begin
      for (int i = 2; i > 0; i--) begin
        m_v[i] = m_v[i-1]; m_rd[i] = m_rd[i-1]; m_rw[i] = m_rw[i-1]; m_mr[i] = m_mr[i-1];
      end
      m_v[0]  = (bus.id_valid && !bus.flush_ex && !lu) ? 1 : 0;
      m_rd[0] = int'(bus.rd_id);
      m_rw[0] = int'(bus.reg_write_id);
      m_mr[0] = int'(bus.mem_read_id);
    end
  endtask

  task automatic check_all();
    chk("stall_id", bus.stall_id, 32'(model_lu() || bus.mem_hold));
    chk("rwen_exmem", bus.reg_write_en_exmem, 32'((m_v[1] != 0) && (m_rw[1] != 0)));
    if (m_v[1] != 0) chk("rd_exmem", bus.rd_exmem, 32'(m_rd[1]));
    chk("rwen_memwb", bus.reg_write_en_memwb, 32'((m_v[2] != 0) && (m_rw[2] != 0)));
    if (m_v[2] != 0) chk("rd_memwb", bus.rd_memwb, 32'(m_rd[2]));
    chk("wb_retire", bus.wb_retire, 32'(m_v[2] != 0));
    chk("stall_count", bus.stall_count, 32'(m_sc));
    chk("retire_count", bus.retire_count, 32'(m_rc));
  endtask

  // One clock: compare against the model, take the edge, advance the model.
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_id(input int v, input int rd, input int rw, input int mr,
                        input int rn, input int urn, input int rm, input int urm);
    bus.id_valid     = v[0];
    bus.rd_id        = rd[RW-1:0];
    bus.reg_write_id = rw[0];
    bus.mem_read_id  = mr[0];
    bus.rn_id        = rn[RW-1:0];
    bus.use_rn_id    = urn[0];
    bus.rm_id        = rm[RW-1:0];
    bus.use_rm_id    = urm[0];
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    bus.flush_ex = 1'b0;
    bus.mem_hold = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_stall_id"}, bus.stall_id, 32'd0);
    chk({tag, "_rd_exmem"}, bus.rd_exmem, 32'd0);
    chk({tag, "_rwen_exmem"}, bus.reg_write_en_exmem, 32'd0);
    chk({tag, "_rd_memwb"}, bus.rd_memwb, 32'd0);
    chk({tag, "_rwen_memwb"}, bus.reg_write_en_memwb, 32'd0);
    chk({tag, "_wb_retire"}, bus.wb_retire, 32'd0);
    chk({tag, "_stall_count"}, bus.stall_count, 32'd0);
    chk({tag, "_retire_count"}, bus.retire_count, 32'd0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    idle();
    model_reset();

    // Reset state and single ADD r3 flowing through.
    do_reset();
    check_zero("reset");
    set_id(1, 3, 1, 0, 0, 0, 0, 0); tick();
    idle(); tick();
    chk("add_rwen_exmem", bus.reg_write_en_exmem, 32'd1);
    chk("add_rd_exmem", bus.rd_exmem, 32'd3);
    tick();
    chk("add_rwen_memwb", bus.reg_write_en_memwb, 32'd1);
    chk("add_rd_memwb", bus.rd_memwb, 32'd3);
    chk("add_retire", bus.wb_retire, 32'd1);
    tick();
    chk("add_retire_off", bus.wb_retire, 32'd0);
    chk("add_retire_count", bus.retire_count, 32'd1);

    // Load-use: LDR r5 then ADD r6 <- r5.
    do_reset();
    set_id(1, 5, 1, 1, 0, 0, 0, 0); tick();
    set_id(1, 6, 1, 0, 5, 1, 0, 0); #1;
    chk("lu_stall_on", bus.stall_id, 32'd1);
    tick();
    chk("lu_load_in_mem", bus.rd_exmem, 32'd5);
    chk("lu_stall_count", bus.stall_count, 32'd1);
    #1;
    chk("lu_stall_off", bus.stall_id, 32'd0);
    tick();
    chk("lu_bubble_mem", bus.reg_write_en_exmem, 32'd0);
    idle(); tick();
    chk("lu_add_rd_mem", bus.rd_exmem, 32'd6);
    chk("lu_add_rwen_mem", bus.reg_write_en_exmem, 32'd1);
    chk("lu_stall_count_end", bus.stall_count, 32'd1);

    // No stall: load to r0, and unused source matching the load.
    do_reset();
    set_id(1, 0, 1, 1, 0, 0, 0, 0); tick();
    set_id(1, 6, 1, 0, 0, 1, 0, 1); #1;
    chk("r0_no_stall", bus.stall_id, 32'd0);
    tick();
    set_id(1, 5, 1, 1, 0, 0, 0, 0); tick();
    set_id(1, 6, 1, 0, 5, 0, 5, 0); #1;
    chk("unused_src_no_stall", bus.stall_id, 32'd0);
    tick();
    idle(); tick();
    chk("nostall_count", bus.stall_count, 32'd0);

    // mem_hold for 3 cycles with LDR r2 in MEM, SUB r4 in EX, ADD r1 in WB.
    do_reset();
    set_id(1, 1, 1, 0, 0, 0, 0, 0); tick();
    set_id(1, 2, 1, 1, 0, 0, 0, 0); tick();
    set_id(1, 4, 1, 0, 3, 1, 0, 0); tick();
    idle();
    chk("hold_pre_retire", bus.wb_retire, 32'd1);
    chk("hold_pre_rd_memwb", bus.rd_memwb, 32'd1);
    bus.mem_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_rd_exmem", bus.rd_exmem, 32'd2);
      chk("hold_rwen_exmem", bus.reg_write_en_exmem, 32'd1);
      chk("hold_wb_bubble", bus.wb_retire, 32'd0);
    end
    chk("hold_stall_count", bus.stall_count, 32'd3);
    chk("hold_retire_count", bus.retire_count, 32'd1);
    bus.mem_hold = 1'b0;
    tick();
    chk("hold_release_exmem", bus.rd_exmem, 32'd4);
    chk("hold_release_memwb", bus.rd_memwb, 32'd2);
    chk("hold_release_retire", bus.wb_retire, 32'd1);

    // Flush kills the instruction entering EX.
    do_reset();
    set_id(1, 7, 1, 0, 0, 0, 0, 0);
    bus.flush_ex = 1'b1; tick();
    idle(); tick();
    chk("flush_rwen_exmem", bus.reg_write_en_exmem, 32'd0);
    tick();
    chk("flush_rwen_memwb", bus.reg_write_en_memwb, 32'd0);
    chk("flush_retire_count", bus.retire_count, 32'd0);

    // Flush under hold is deferred until hold drops.
    do_reset();
    set_id(1, 7, 1, 0, 0, 0, 0, 0);
    bus.flush_ex = 1'b1;
    bus.mem_hold = 1'b1; tick();
    bus.mem_hold = 1'b0; tick();
    bus.flush_ex = 1'b0;
    set_id(1, 8, 1, 0, 0, 0, 0, 0); tick();
    chk("defer_rwen_exmem", bus.reg_write_en_exmem, 32'd0);
    idle(); tick();
    chk("defer_rd_exmem", bus.rd_exmem, 32'd8);
    chk("defer_rwen_exmem2", bus.reg_write_en_exmem, 32'd1);

    // Stall counter saturation.
    do_reset();
    bus.mem_hold = 1'b1;
    repeat (20) tick();
    chk("stall_saturate", bus.stall_count, 32'd15);
    idle();

    // Randomized traffic with an asynchronous reset in the middle.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        idle();
        #2 rst_n = 1'b0;
        #1 check_zero("async");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
      end
      set_id(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 7),
             ($urandom_range(0, 4) != 0) ? 1 : 0, ($urandom_range(0, 2) == 0) ? 1 : 0,
             $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 1));
      bus.flush_ex = ($urandom_range(0, 9) == 0);
      bus.mem_hold = ($urandom_range(0, 6) == 0);
      tick();
    end
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dest_tag_pipeline.md
Name: dest_tag_pipeline

Overview:
Producer side of the operand-forwarding interface. It carries each instruction's destination tag (rd, reg-write, load flag) from ID through the ID/EX, EX/MEM and MEM/WB pipeline stages. It drives the rd/reg-write-enable pairs that the forwarding unit compares against, and it detects load-use hazards it cannot resolve by forwarding. It also owns pipeline hold/flush sequencing for tags, plus stall and retire performance counters.

Parameters:
REG_ADDR_W, 4, register-index width (16 architectural registers; r0 never a forwarding or hazard source)
CNT_W, 16, width of the stall and retire counters

Ports:
clk  input  1  single pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID stage holds a real instruction
rd_id  input  REG_ADDR_W  destination register of ID instruction
reg_write_id  input  1  ID instruction writes rd
mem_read_id  input  1  ID instruction is a load
rn_id  input  REG_ADDR_W  source register 1 of ID instruction
rm_id  input  REG_ADDR_W  source register 2 of ID instruction
use_rn_id  input  1  ID instruction actually reads rn
use_rm_id  input  1  ID instruction actually reads rm
flush_ex  input  1  taken branch resolved in EX; kill the instruction entering ID/EX
mem_hold  input  1  data memory not ready; freeze EX and MEM stages
stall_id  output  1  hold PC and IF/ID this cycle (combinational)
rd_exmem  output  REG_ADDR_W  destination register in EX/MEM
reg_write_en_exmem  output  1  EX/MEM valid and writes rd
rd_memwb  output  REG_ADDR_W  destination register in MEM/WB
reg_write_en_memwb  output  1  MEM/WB valid and writes rd
wb_retire  output  1  MEM/WB holds a valid instruction (one-cycle retire marker)
stall_count  output  CNT_W  cycles with stall_id high, saturating
retire_count  output  CNT_W  retired instructions, wrapping

Behaviour:
- Three tag stages: EX (ID/EX), MEM (EX/MEM), WB (MEM/WB). Each stage holds {valid, rd, reg_write, mem_read}.
- Reset (async, rst_n low):
  - All stage valids = 0 and all rd = 0.
  - reg_write_en_* = 0, wb_retire = 0, stall_count = 0, retire_count = 0.
  - stall_id is combinational and reads 0 while stages are empty.
- Derived outputs:
  - reg_write_en_exmem = MEM.valid & MEM.reg_write; reg_write_en_memwb = WB.valid & WB.reg_write.
  - rd_exmem and rd_memwb come straight from the stage registers.
  - wb_retire = WB.valid.
- load_use = id_valid & EX.valid & EX.mem_read & EX.reg_write & (EX.rd != 0) & ((use_rn_id & rn_id == EX.rd) | (use_rm_id & rm_id == EX.rd)).
- stall_id = load_use | mem_hold.
- Per-edge update, first matching rule wins:
  1. mem_hold=1: EX and MEM hold their contents. WB loads a bubble (valid=0), so the WB instruction retires exactly once. flush_ex is ignored; the branch unit holds flush_ex until mem_hold drops.
  2. flush_ex=1: EX loads a bubble, MEM <= EX, WB <= MEM.
  3. load_use=1: EX loads a bubble, MEM <= EX, WB <= MEM. The ID instruction is re-presented next cycle.
  4. Otherwise: EX <= {id_valid, rd_id, reg_write_id, mem_read_id}, MEM <= EX, WB <= MEM.
- Load-use costs exactly one bubble. On the following cycle the load is in MEM, and the forwarding unit's MEM/WB path covers it one cycle later.
- Loads targeting r0 (or with reg_write=0) never stall.
- Counters:
  - stall_count increments every cycle stall_id=1 and saturates at all-ones.
  - retire_count increments every cycle WB.valid=1 and wraps modulo 2^CNT_W.
- A bubble stage keeps its rd field but has valid=0, so its reg_write_en outputs are 0.
- Reset asserted mid-operation clears all in-flight tags immediately. After release, the first valid ID instruction appears on EX/MEM outputs 2 edges later.

Test Plan:
- Reset, then ADD r3 (valid, rd=3, reg_write=1) in ID for one cycle, then idle -> reg_write_en_exmem=1 with rd_exmem=3 after edge 2; reg_write_en_memwb=1 with rd_memwb=3 after edge 3; wb_retire pulses once; retire_count=1.
- LDR r5 followed by ADD using rn=5, use_rn=1 -> stall_id=1 for exactly one cycle; one bubble in EX; stall_count=1; ADD reaches MEM two cycles after the load's MEM.
- LDR r0 followed by a consumer of r0, and LDR r5 followed by a consumer with use_rn=0 and rn=5 -> no stall in either case.
- mem_hold high for 3 cycles with LDR r2 in MEM and SUB r4 in EX -> rd_exmem stays 2 throughout; WB shows one retire then bubbles; stall_count +3; after release, tags advance normally.
- flush_ex pulse with ID valid (rd=7) -> EX gets a bubble; rd=7 never appears with reg_write_en_exmem=1.
- flush_ex with mem_hold both high -> flush deferred; applied on the first cycle mem_hold=0 (flush held high). Separately: drive stall_id continuously past 2^CNT_W cycles (CNT_W=4 build) -> stall_count saturates at 15; rst_n low mid-stream -> all outputs 0 asynchronously.
